// File: rtl/s2p_framed.sv
// ============================================================================
// Module   : s2p_framed
// Purpose  : Framed serial-to-parallel converter with bit-strobe pacing,
//            selectable bit order and a DEPTH-entry output queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module s2p_framed #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         bit_en,
  input  logic                         sync,
  input  logic                         data_in,
  output logic                         valid,
  input  logic                         ack,
  output logic [WIDTH-1:0]             dataout,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_lvl_w = $clog2(DEPTH + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     w_shift_nxt;
  logic                 w_shift_en;
  logic                 w_push;
  logic                 w_frame_err;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr;
  logic [c_ptr_w-1:0]   r_rd;
  logic [c_lvl_w-1:0]   r_count;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;
  logic                 r_frame_err;
  logic                 r_overrun;

  // The shifted value doubles as the completed word on the final strobe.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_nxt = {r_shift[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign w_shift_nxt = {data_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_shift_en) begin
        r_shift <= w_shift_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    if (bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (sync) begin
            w_shift_en  = 1'b1;
            w_cnt_nxt   = c_cnt_one;
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          w_shift_en = 1'b1;
          if (sync) begin
            // Any sync inside a word aborts it and restarts on this bit.
            w_frame_err = 1'b1;
            w_cnt_nxt   = c_cnt_one;
          end else if (r_cnt == c_cnt_last) begin
            w_push      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid && ack;
  assign w_push_ok = w_push && ((r_count != c_lvl_full) || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= w_shift_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_drop;
      if (w_push_ok) begin
        r_wr <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_lvl_w'(1);
        2'b01:   r_count <= r_count - c_lvl_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid     = w_valid;
  assign dataout   = w_valid ? r_mem[r_rd] : '0;
  assign level     = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_s2p_framed.sv
// ============================================================================
// Module   : tb_s2p_framed
// Purpose  : Self-checking bench for s2p_framed, MSB-first and LSB-first side by side.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_s2p_framed;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       sync = 1'b0;
  logic       data_in = 1'b0;
  logic       ack = 1'b0;
  logic       valid_m, valid_l, fe_m, fe_l, ov_m, ov_l;
  logic [7:0] do_m, do_l;
  logic [1:0] lv_m, lv_l;

  s2p_framed #(.WIDTH(8), .DEPTH(D), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .sync(sync), .data_in(data_in),
    .valid(valid_m), .ack(ack), .dataout(do_m), .level(lv_m),
    .frame_err(fe_m), .overrun(ov_m));

  s2p_framed #(.WIDTH(8), .DEPTH(D), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .sync(sync), .data_in(data_in),
    .valid(valid_l), .ack(ack), .dataout(do_l), .level(lv_l),
    .frame_err(fe_l), .overrun(ov_l));

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         m_level = 0;
  logic [7:0] sbm[$];
  logic [7:0] sbl[$];

  typedef struct {
    logic [7:0] pat;    // pat[7] is sent first
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic s, input logic d, input logic a);
    bit_en = 1'b1; sync = s; data_in = d; ack = a;
    tick();
    bit_en = 1'b0; sync = 1'b0; data_in = 1'b0; ack = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] em, input logic [7:0] el, output logic ov);
    if (m_level < D) begin
      sbm.push_back(em);
      sbl.push_back(el);
      m_level++;
      ov = 1'b0;
    end else begin
      ov = 1'b1;
    end
  endtask

  task automatic post_word_checks(input logic exp_ov);
    check("overrun_m", ov_m, exp_ov);
    check("overrun_l", ov_l, exp_ov);
    check("frame_err_m", fe_m, 0);
    check("level_m", lv_m, m_level);
    check("level_l", lv_l, m_level);
  endtask

  task automatic pre_pop_checks();
    check("valid_m", valid_m, 1);
    check("valid_l", valid_l, 1);
    if (sbm.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: got empty queue, expected a word");
    end else begin
      check("data_m", do_m, sbm.pop_front());
      check("data_l", do_l, sbl.pop_front());
      m_level--;
    end
  endtask

  // ack_last asserts ack together with the final bit (push and pop on one edge)
  task automatic send_word(input logic [7:0] pat, input logic [7:0] em,
                           input logic [7:0] el, input logic ack_last);
    logic ov;
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && ack_last) pre_pop_checks();
      strobe(i == 0, pat[7-i], (i == 7) && ack_last);
    end
    model_push(em, el, ov);
    post_word_checks(ov);
  endtask

  task automatic pop_check();
    pre_pop_checks();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("level_after_pop", lv_m, m_level);
    check("level_after_pop_l", lv_l, m_level);
  endtask

  // nb bits of a doomed word, then a sync that starts pat
  task automatic early_sync(input int nb, input logic [7:0] pat,
                            input logic [7:0] em, input logic [7:0] el);
    logic ov;
    for (int i = 0; i < nb; i++) strobe(i == 0, 1'b1, 1'b0);
    strobe(1'b1, pat[7], 1'b0);
    check("early_fe_m", fe_m, 1);
    check("early_fe_l", fe_l, 1);
    check("early_no_push", lv_m, m_level);
    for (int i = 1; i < 8; i++) begin
      strobe(1'b0, pat[7-i], 1'b0);
      if (i == 1) check("early_fe_clear", fe_m, 0);
    end
    model_push(em, el, ov);
    post_word_checks(ov);
  endtask

  initial begin
    logic ov;
    vecs[0] = '{pat: 8'hC0, exp_m: 8'hC0, exp_l: 8'h03};
    vecs[1] = '{pat: 8'h11, exp_m: 8'h11, exp_l: 8'h88};
    vecs[2] = '{pat: 8'h5A, exp_m: 8'h5A, exp_l: 8'h5A};
    vecs[3] = '{pat: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
    vecs[4] = '{pat: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
    vecs[5] = '{pat: 8'h3C, exp_m: 8'h3C, exp_l: 8'h3C};

    tick(); tick();
    check("rst_valid", valid_m, 0);
    check("rst_data", do_m, 0);
    check("rst_level", lv_m, 0);
    check("rst_fe", fe_m, 0);
    check("rst_ov", ov_l, 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].pat, vecs[v].exp_m, vecs[v].exp_l, 1'b0);
      for (int h = 0; h < ((v == 0) ? 5 : 2); h++) begin
        tick();
        check("hold_m", do_m, vecs[v].exp_m);
        check("hold_valid", valid_m, 1);
      end
      pop_check();
      check("empty_valid", valid_m, 0);
      check("empty_data_m", do_m, 0);
      check("empty_data_l", do_l, 0);
    end

    // 0xA5 with two idle (bit_en=0) cycles after every bit, garbage on sync/data_in
    for (int i = 0; i < 8; i++) begin
      logic [7:0] p;
      p = 8'hA5;
      strobe(i == 0, p[7-i], 1'b0);
      for (int g = 0; g < 2; g++) begin
        sync = 1'b1; data_in = ~p[7-i];
        tick();
      end
      sync = 1'b0; data_in = 1'b0;
    end
    model_push(8'hA5, 8'hA5, ov);
    post_word_checks(ov);
    pop_check();

    early_sync(4, 8'h3C, 8'h3C, 8'h3C);
    pop_check();
    early_sync(7, 8'h81, 8'h81, 8'h81);
    pop_check();

    // Fill, overrun, then push-with-pop while full
    send_word(8'h11, 8'h11, 8'h88, 1'b0);
    send_word(8'h22, 8'h22, 8'h44, 1'b0);
    send_word(8'h33, 8'h33, 8'hCC, 1'b0);
    tick();
    check("ov_clear", ov_m, 0);
    check("full_level", lv_m, 2);
    send_word(8'h44, 8'h44, 8'h22, 1'b1);
    pop_check();
    pop_check();
    check("drained_level", lv_m, 0);

    // Reset with one word queued and another half received
    send_word(8'h77, 8'h77, 8'hEE, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_valid", valid_m, 0);
    check("arst_data_m", do_m, 0);
    check("arst_level_l", lv_l, 0);
    sbm.delete(); sbl.delete(); m_level = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_fe", fe_m, 0);
    check("arst_ov", ov_m, 0);
    send_word(8'h5A, 8'h5A, 8'h5A, 1'b0);
    pop_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/s2p_framed.md
# s2p_framed

Parametrised serial-to-parallel converter with framing, bit-strobe pacing, selectable bit order and a small output queue. It sits between a single-bit serial receive line and a word-wide consumer. Words are delimited by `sync` and handed over on a valid/ack handshake. Up to DEPTH completed words are buffered, so capture continues while the consumer is slow. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `DEPTH`, 2: output queue depth in words; power of two, 1..8.
- `MSB_FIRST`, 1: 1 = first serial bit lands in `dataout[WIDTH-1]`; 0 = first bit lands in `dataout[0]`.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `bit_en` in 1: bit strobe; `data_in` and `sync` are only sampled when it is 1.
- `sync` in 1: with `bit_en`, marks the current `data_in` as bit 0 of a new word.
- `data_in` in 1: serial data.
- `valid` out 1: queue non-empty; `dataout` holds the oldest word.
- `ack` in 1: consumer accepts the head word; acts only when `valid`=1.
- `dataout` out WIDTH: head word when `valid`=1, otherwise all zeros.
- `level` out $clog2(DEPTH+1): number of words queued.
- `frame_err` out 1: one-cycle pulse; a word was aborted by an early `sync`.
- `overrun` out 1: one-cycle pulse; a completed word was dropped because the queue was full.

## Operation
- Clock and reset: one clock domain. `reset_n`=0 asynchronously sets:
  - state to IDLE,
  - the bit counter, shift register and queue pointers to 0,
  - `valid`, `level`, `frame_err` and `overrun` to 0 (so `dataout` reads 0).
- Bit counter: $clog2(WIDTH) bits. It counts bits captured in the current word.
- State machine (2 states). A "strobe" is a cycle with `bit_en`=1; when `bit_en`=0 nothing changes in either state.
  - IDLE: a strobe with `sync`=0 is ignored. A strobe with `sync`=1 captures `data_in` as bit 0, sets the counter to 1 and moves to SHIFT.
  - SHIFT, strobe with `sync`=0: captures `data_in`.
    - If the counter is below WIDTH-1, it increments.
    - If the counter equals WIDTH-1, the word is complete: it is pushed, the counter clears and the state returns to IDLE.
  - SHIFT, strobe with `sync`=1, counter below WIDTH-1: the partial word is discarded and `frame_err` pulses. `data_in` becomes bit 0 of a new word, the counter is set to 1 and the state stays SHIFT.
  - SHIFT, strobe with `sync`=1, counter equal to WIDTH-1: this is an early start of the next word. The partial word is discarded, `frame_err` pulses, `data_in` becomes bit 0 and the counter is set to 1.
- Bit ordering:
  - MSB_FIRST=1: the shift register shifts left and the new bit enters at LSB.
  - MSB_FIRST=0: the shift register shifts right and the new bit enters at MSB.
  - After WIDTH bits, the first bit sits at the position given by `MSB_FIRST`.
- Completed-word assembly: the word is formed combinationally from the shift register plus the final `data_in`, and is written to the queue on the same edge.
- Queue: circular buffer of DEPTH entries with read and write pointers and a count.
  - Pop: `valid`=1 and `ack`=1.
  - Push is accepted when `level`<DEPTH, or when `level`=DEPTH and a pop happens in the same cycle.
  - Otherwise the completed word is dropped, `overrun` pulses, and the queue is unchanged.
  - Simultaneous push and pop leaves `level` unchanged. Pointers wrap modulo DEPTH.
- `ack` with `valid`=0 is ignored. `ack` does not affect capture.

## Timing
- Capture latency: the final bit is sampled at edge N. From after edge N, `valid`=1, `level` is incremented and `dataout` shows the word, provided the queue was empty.
- Hold: `dataout` and `valid` hold until the edge on which `ack`=1 is sampled. The next queued word, or zero, appears after that edge.
- Throughput: with `bit_en` held at 1, a `sync` strobe can start the next word on the cycle right after the last bit of the previous word. There are no dead cycles.
- Pulse timing: `frame_err` and `overrun` are registered. Each is high for exactly the one cycle after the offending edge.
- Reset mid-word or with words queued: all contents are lost. `valid`=0 immediately; no pulses are emitted.

## Test plan
- MSB_FIRST=1, WIDTH=8, `bit_en`=1: `sync` with bits 1,1,0,0,0,0,0,0 -> after 8th edge `valid`=1, `dataout`=0xC0, `level`=1. Hold `ack` low 5 cycles: value stable. `ack`=1 for 1 cycle -> `valid`=0, `dataout`=0x00.
- MSB_FIRST=0, same bits -> `dataout`=0x03.
- `bit_en` toggling 1,0,0,1,... during 0xA5 (MSB first) -> same 0xA5. Bits on `bit_en`=0 cycles are ignored.
- Early `sync` on the 5th bit -> `frame_err` high 1 cycle, no push. The next 8 strobes (starting at that `sync`) yield the new word correctly.
- DEPTH=2, three back-to-back words 0x11, 0x22, 0x33, no `ack` -> `level`=2, `overrun` pulses after the third word. Then two acks return 0x11, then 0x22, and `level`=0.
- `reset_n` low mid-word and with `level`=1 -> outputs zero at once. After release, a fresh word 0x5A is captured correctly.
